// File: rtl/capture_readout_sequencer.sv
// Capture-and-readout sequencer for the compressed camera image.
// Gates CCD capture, reloads the SDRAM read FIFOs, generates the read-FIFO
// clock itself and hands each packed 32-bit word to the HPS over a 4-phase
// valid/ack handshake.
// Optional capture watchdog: define CRS_TIMEOUT_EN to enable the ERROR path.
module capture_readout_sequencer #(
  parameter int WORDS       = 9600,
  parameter int IDX_W       = 14,
  parameter int LOAD_CYC    = 4,
  parameter int FRAMES      = 1,
  parameter int SETTLE_CYC  = 1024,
  parameter int RD_HALF     = 2,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic             iFVAL,
  input  logic             iACK,
  output logic             oCAPTURE,
  output logic             oRD_LOAD,
  output logic             oRD_CLK,
  output logic             oVALID,
  output logic [IDX_W-1:0] oWORD_IDX,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR,
  output logic [2:0]       oSTATE
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    CAPTURE  = 3'd2,
    SETTLE   = 3'd3,
    RD_PULSE = 3'd4,
    RD_WAIT  = 3'd5,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } state_t;

  // Handshake sub-phase inside RD_WAIT: guard against a stale ack, present
  // the word, then wait for the ack to be released.
  typedef enum logic [1:0] {
    W_GUARD = 2'd0,
    W_VALID = 2'd1,
    W_REL   = 2'd2
  } wphase_t;

  localparam int CNT_MAX_A = (LOAD_CYC > SETTLE_CYC) ? LOAD_CYC : SETTLE_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > 2 * RD_HALF) ? CNT_MAX_A : 2 * RD_HALF;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int FR_W      = $clog2(FRAMES + 1);

  state_t           state, state_nxt;
  wphase_t          wphase, wphase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [FR_W-1:0]  frame_cnt, frame_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             seen, seen_nxt;
  logic             fval_s1, fval_s2;
  logic             frame_end, frame_done;
  logic             capture_nxt, load_nxt, rdclk_nxt, valid_nxt, done_nxt, err_nxt;

`ifdef CRS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] tcnt, tcnt_nxt;
`endif

  // Frame end: synchronised frame-valid falls after a high was seen in CAPTURE.
  assign frame_end  = (state == CAPTURE) && seen && !fval_s2;
  assign frame_done = frame_end && (frame_cnt == FR_W'(FRAMES - 1));

  assign oBUSY  = (state != IDLE) && (state != DONE) && (state != ERROR);
  assign oSTATE = state;

  // Two-flop synchroniser bringing frame-valid from the pixel clock domain.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_s1 <= 1'b0;
      fval_s2 <= 1'b0;
    end else begin
      fval_s1 <= iFVAL;
      fval_s2 <= fval_s1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      wphase    <= W_GUARD;
      cnt       <= '0;
      frame_cnt <= '0;
      seen      <= 1'b0;
      oWORD_IDX <= '0;
      oCAPTURE  <= 1'b0;
      oRD_LOAD  <= 1'b0;
      oRD_CLK   <= 1'b0;
      oVALID    <= 1'b0;
      oDONE     <= 1'b0;
      oERR      <= 1'b0;
`ifdef CRS_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      wphase    <= wphase_nxt;
      cnt       <= cnt_nxt;
      frame_cnt <= frame_nxt;
      seen      <= seen_nxt;
      oWORD_IDX <= idx_nxt;
      oCAPTURE  <= capture_nxt;
      oRD_LOAD  <= load_nxt;
      oRD_CLK   <= rdclk_nxt;
      oVALID    <= valid_nxt;
      oDONE     <= done_nxt;
      oERR      <= err_nxt;
`ifdef CRS_TIMEOUT_EN
      tcnt      <= tcnt_nxt;
`endif
    end
  end

  // Next-state logic; outputs are derived from the next state so they change on the same edge.
  always_comb begin
    state_nxt  = state;
    wphase_nxt = wphase;
    cnt_nxt    = cnt;
    frame_nxt  = frame_cnt;
    seen_nxt   = 1'b0;
    idx_nxt    = oWORD_IDX;
`ifdef CRS_TIMEOUT_EN
    tcnt_nxt   = '0;
`endif

    case (state)
      IDLE: begin
        idx_nxt = '0;
        cnt_nxt = '0;
        if (iSTART) state_nxt = ARM;
      end
      ARM: begin
        if (cnt == CNT_W'(LOAD_CYC - 1)) begin
          state_nxt = CAPTURE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CAPTURE: begin
        seen_nxt = seen | fval_s2;
        frame_nxt = '0;
`ifdef CRS_TIMEOUT_EN
        tcnt_nxt = tcnt + 1'b1;
`endif
        if (frame_end) begin
          seen_nxt = 1'b0;
          if (frame_done) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else begin
            frame_nxt = frame_cnt + 1'b1;
          end
        end else begin
          frame_nxt = frame_cnt;
        end
`ifdef CRS_TIMEOUT_EN
        if (!frame_done && (tcnt == TO_W'(TIMEOUT_CYC - 1))) begin
          state_nxt = ERROR;
          tcnt_nxt  = '0;
        end
`endif
      end
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          state_nxt = RD_PULSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RD_PULSE: begin
        if (cnt == CNT_W'(2 * RD_HALF - 1)) begin
          state_nxt  = RD_WAIT;
          cnt_nxt    = '0;
          wphase_nxt = iACK ? W_GUARD : W_VALID;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RD_WAIT: begin
        case (wphase)
          W_GUARD: if (!iACK) wphase_nxt = W_VALID;
          W_VALID: if (iACK) wphase_nxt = W_REL;
          W_REL: begin
            if (!iACK) begin
              wphase_nxt = W_GUARD;
              if (oWORD_IDX == IDX_W'(WORDS - 1)) begin
                state_nxt = DONE;
              end else begin
                state_nxt = RD_PULSE;
                cnt_nxt   = '0;
                idx_nxt   = oWORD_IDX + 1'b1;
              end
            end
          end
          default: wphase_nxt = W_GUARD;
        endcase
      end
      DONE:    state_nxt = state;
      ERROR:   state_nxt = state;
      default: state_nxt = IDLE;
    endcase

    // Dropping iSTART anywhere outside IDLE returns to IDLE and wins over any other move.
    if ((state != IDLE) && !iSTART) begin
      state_nxt  = IDLE;
      wphase_nxt = W_GUARD;
      cnt_nxt    = '0;
      frame_nxt  = '0;
      seen_nxt   = 1'b0;
      idx_nxt    = '0;
`ifdef CRS_TIMEOUT_EN
      tcnt_nxt   = '0;
`endif
    end

    capture_nxt = (state_nxt == CAPTURE);
    load_nxt    = (state_nxt == ARM);
    rdclk_nxt   = (state_nxt == RD_PULSE) && (cnt_nxt < CNT_W'(RD_HALF));
    valid_nxt   = (state_nxt == RD_WAIT) && (wphase_nxt == W_VALID);
    done_nxt    = (state_nxt == DONE);
    err_nxt     = (state_nxt == ERROR);
  end

endmodule

// File: tb/tb_capture_readout_sequencer.sv
// Directed self-checking bench for capture_readout_sequencer (small frame).
module tb_capture_readout_sequencer;

  localparam int WORDS = 4;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             fval;
  logic             ack;
  logic             capture, rd_load, rd_clk, valid, busy, done, err;
  logic [IDX_W-1:0] word_idx;
  logic [2:0]       state;

  int tests_run    = 0;
  int tests_failed = 0;

  capture_readout_sequencer #(
    .WORDS(WORDS), .IDX_W(IDX_W), .LOAD_CYC(4), .FRAMES(1),
    .SETTLE_CYC(8), .RD_HALF(2), .TIMEOUT_CYC(100)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iFVAL(fval), .iACK(ack),
    .oCAPTURE(capture), .oRD_LOAD(rd_load), .oRD_CLK(rd_clk), .oVALID(valid),
    .oWORD_IDX(word_idx), .oBUSY(busy), .oDONE(done), .oERR(err), .oSTATE(state)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case the design never reaches an expected state.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance negedges until the state code matches or the budget runs out.
  task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
    for (int i = 0; i < limit && state != s; i++) @(negedge clk);
    checkOutput(tag, state, s);
  endtask

  // One frame-valid pulse from the sensor.
  task automatic drive_frame();
    fval = 1'b1;
    repeat (4) @(negedge clk);
    fval = 1'b0;
  endtask

  // Reads one word starting from the negedge of its RD_PULSE (or just before).
  task automatic read_word(input int exp_idx, input int ack_delay, input bit stale);
    int pulse_cyc = 0;
    int clk_hi = 0;
    int held = 0;
    int extra = 0;
    int stale_valid = 0;
    for (int i = 0; i < 200 && state != 3'd5; i++) begin
      if (state == 3'd4) begin
        pulse_cyc++;
        if (rd_clk) clk_hi++;
        if (stale) ack = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("w%0d_enter_wait", exp_idx), state, 3'd5);
    checkOutput($sformatf("w%0d_pulse_len", exp_idx), pulse_cyc, 4);
    checkOutput($sformatf("w%0d_clk_high", exp_idx), clk_hi, 2);
    checkOutput($sformatf("w%0d_idx", exp_idx), word_idx, exp_idx);
    if (stale) begin
      repeat (3) begin
        if (valid) stale_valid++;
        @(negedge clk);
      end
      checkOutput("stale_ack_no_valid", stale_valid, 0);
      checkOutput("stale_ack_idx", word_idx, exp_idx);
      ack = 1'b0;
    end
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    for (int i = 0; i < ack_delay; i++) begin
      if (valid) held++;
      if (rd_clk) extra++;
      if (i != ack_delay - 1) @(negedge clk);
    end
    ack = 1'b1;
    checkOutput($sformatf("w%0d_valid_held", exp_idx), held, ack_delay);
    if (ack_delay > 1) checkOutput("no_extra_rdclk", extra, 0);
    @(negedge clk);
    checkOutput($sformatf("w%0d_valid_drop", exp_idx), valid, 1'b0);
    checkOutput($sformatf("w%0d_idx_hold", exp_idx), word_idx, exp_idx);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int load_cnt;
    int settle_cnt;
    int cap_cnt;
    rst_n = 1'b0;
    start = 1'b0;
    fval  = 1'b0;
    ack   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {capture, rd_load, rd_clk, valid, done, err, busy, state, word_idx}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full run: load timing, capture, settle, four words (word 1 slow ack, word 2 stale ack).
    start = 1'b1;
    load_cnt = 0;
    for (int i = 0; i < 30 && state != 3'd2; i++) begin
      @(negedge clk);
      if (rd_load) load_cnt++;
    end
    checkOutput("load_cycles", load_cnt, 4);
    checkOutput("capture_high", capture, 1'b1);
    checkOutput("busy_capture", busy, 1'b1);
    drive_frame();
    wait_state(3'd3, 30, "enter_settle");
    checkOutput("capture_low_settle", capture, 1'b0);
    settle_cnt = 0;
    for (int i = 0; i < 40 && state == 3'd3; i++) begin
      settle_cnt++;
      @(negedge clk);
    end
    checkOutput("settle_cycles", settle_cnt, 8);
    read_word(0, 1, 1'b0);
    read_word(1, 10, 1'b0);
    read_word(2, 1, 1'b1);
    read_word(3, 1, 1'b0);
    checkOutput("done_state", state, 3'd6);
    checkOutput("done_flag", done, 1'b1);
    checkOutput("done_idx_sat", word_idx, WORDS - 1);
    checkOutput("done_not_busy", busy, 1'b0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("release_idle", {done, state, word_idx}, 0);

    // Abort in RD_PULSE while the FIFO clock is high.
    start = 1'b1;
    wait_state(3'd2, 30, "t4_capture");
    drive_frame();
    wait_state(3'd4, 60, "t4_rd_pulse");
    checkOutput("t4_rdclk_high", rd_clk, 1'b1);
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort_outputs", {state, rd_clk, valid, busy}, 0);

    // Asynchronous reset in the middle of CAPTURE, then a normal re-run.
    start = 1'b1;
    wait_state(3'd2, 30, "t5_capture");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset",
                {capture, rd_load, rd_clk, valid, done, err, busy, state, word_idx}, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    wait_state(3'd2, 30, "t5_rerun_capture");
    drive_frame();
    wait_state(3'd4, 60, "t5_rerun_pulse");
    for (int w = 0; w < WORDS; w++) read_word(w, 1, 1'b0);
    checkOutput("t5_rerun_done", {done, state}, {1'b1, 3'd6});
    start = 1'b0;
    @(negedge clk);

    // Capture with no frame activity.
    start = 1'b1;
    wait_state(3'd2, 30, "t6_capture");
    cap_cnt = 0;
`ifdef CRS_TIMEOUT_EN
    for (int i = 0; i < 300 && state == 3'd2; i++) begin
      cap_cnt++;
      @(negedge clk);
    end
    checkOutput("wd_capture_cycles", cap_cnt, 100);
    checkOutput("wd_state_error", state, 3'd7);
    checkOutput("wd_err_flag", err, 1'b1);
    checkOutput("wd_capture_off", capture, 1'b0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("wd_release", {state, err}, 0);
`else
    for (int i = 0; i < 150; i++) begin
      if (state == 3'd2) cap_cnt++;
      @(negedge clk);
    end
    checkOutput("no_wd_still_capturing", cap_cnt, 150);
    checkOutput("no_wd_err_low", err, 1'b0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("no_wd_abort", {state, capture}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
